regs_bank: RTL and testbench

REGS_BANK -- requirements
Module: regs_bank

---
 rtl/regs_bank.sv | 146 ++++++++++++++
 tb/tb_regs_bank.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/regs_bank.sv
// Parameterised control/status register bank with a small request FSM.
// Registers are RW, read-only (sourced from hw_in) or write-1-to-clear status.
module regs_bank #(
   parameter int                    DATA_DEPTH   = 16,
   parameter int                    DATA_WIDTH   = 8,
   parameter int                    READ_LATENCY = 1,
   parameter logic [DATA_DEPTH-1:0] RO_MASK      = '0,
   parameter logic [DATA_DEPTH-1:0] W1C_MASK     = '0,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL    = '0,
   localparam int                   ADDR_WIDTH   = $clog2(DATA_DEPTH),
   localparam int                   BE_WIDTH     = DATA_WIDTH / 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             write_en,
   input  logic                             read_en,
   input  logic [ADDR_WIDTH-1:0]            addr,
   input  logic [DATA_WIDTH-1:0]            write_data,
   input  logic [BE_WIDTH-1:0]              byte_en,
   input  logic [DATA_DEPTH*DATA_WIDTH-1:0] hw_in,
   output logic [DATA_WIDTH-1:0]            read_data,
   output logic                             data_ready,
   output logic                             write_done,
   output logic                             err,
   output logic                             busy
);

   typedef enum logic [1:0] {IDLE, WR_RESP, RD_WAIT, RD_RESP} state_t;

   state_t                                 state;
   logic   [2:0]                           cnt;
   logic                                   wr_prev;
   logic                                   rd_prev;
   logic                                   post_rst;
   logic   [ADDR_WIDTH-1:0]                rd_addr;
   logic                                   rd_ok;
   logic   [DATA_WIDTH-1:0]                regs [DATA_DEPTH];
   logic   [DATA_DEPTH-1:0][DATA_WIDTH-1:0] hw_vec;

   logic                  wr_rise;
   logic                  rd_rise;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  addr_ok;
   logic                  wr_err;
   logic                  rd_fire;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic                  sel_ok;
   logic [DATA_WIDTH-1:0] be_mask;
   logic [DATA_WIDTH-1:0] rd_val;
   logic [DATA_DEPTH-1:0] wr_hit;

   assign hw_vec = hw_in;

   // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      wr_rise  = write_en & ~wr_prev & ~post_rst;
      rd_rise  = read_en & ~rd_prev & ~post_rst;
      wr_acc   = (state == IDLE) & wr_rise;
      rd_acc   = (state == IDLE) & rd_rise & ~wr_rise;
      addr_ok  = int'(addr) < DATA_DEPTH;
      wr_err   = ~addr_ok | rd_rise | (addr_ok & RO_MASK[addr]);
      rd_fire  = (rd_acc && READ_LATENCY == 1) || (state == RD_WAIT && cnt == 3'd1);
      // A single-cycle read fires at acceptance, before rd_addr has been latched.
      sel_addr = (state == IDLE) ? addr : rd_addr;
      sel_ok   = (state == IDLE) ? addr_ok : rd_ok;
      be_mask  = '0;
      for (int b = 0; b < BE_WIDTH; b++) be_mask[b*8 +: 8] = {8{byte_en[b]}};
      rd_val   = '0;
      if (sel_ok) rd_val = RO_MASK[sel_addr] ? hw_vec[sel_addr] : regs[sel_addr];
      wr_hit   = '0;
      for (int i = 0; i < DATA_DEPTH; i++) wr_hit[i] = wr_acc & addr_ok & (int'(addr) == i);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         wr_prev    <= 1'b0;
         rd_prev    <= 1'b0;
         post_rst   <= 1'b1;
         rd_addr    <= '0;
         rd_ok      <= 1'b0;
         read_data  <= '0;
         data_ready <= 1'b0;
         write_done <= 1'b0;
         err        <= 1'b0;
         busy       <= 1'b0;
      end else begin
         wr_prev    <= write_en;
         rd_prev    <= read_en;
         post_rst   <= 1'b0;
         data_ready <= 1'b0;
         write_done <= 1'b0;
         err        <= 1'b0;
         unique case (state)
            IDLE: begin
               if (wr_acc) begin
                  state      <= WR_RESP;
                  busy       <= 1'b1;
                  write_done <= 1'b1;
                  err        <= wr_err;
               end else if (rd_acc) begin
                  rd_addr <= addr;
                  rd_ok   <= addr_ok;
                  busy    <= 1'b1;
                  cnt     <= 3'(READ_LATENCY - 1);
                  state   <= (READ_LATENCY == 1) ? RD_RESP : RD_WAIT;
               end
            end
            RD_WAIT: begin
               cnt <= cnt - 3'd1;
               if (cnt == 3'd1) state <= RD_RESP;
            end
            WR_RESP, RD_RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
         if (rd_fire) begin
            data_ready <= 1'b1;
            err        <= ~sel_ok;
            read_data  <= rd_val;
         end
      end
   end

   // NOTE: the bank is plain flops, not a RAM, so each entry takes a reset value.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DATA_DEPTH; i++) begin
         if (rst) begin
            regs[i] <= (RO_MASK[i] | W1C_MASK[i]) ? '0 : RESET_VAL;
         end else if (RO_MASK[i]) begin
            regs[i] <= '0;
         end else if (W1C_MASK[i]) begin
            // Hardware set is OR-ed after the clear so it wins a same-cycle race.
            regs[i] <= (regs[i] & ~(wr_hit[i] ? (write_data & be_mask) : '0)) | hw_vec[i];
         end else if (wr_hit[i]) begin
            regs[i] <= (regs[i] & ~be_mask) | (write_data & be_mask);
         end
      end
   end

endmodule

// File: tb/tb_regs_bank.sv
// Directed bench for regs_bank: an 8-bit/12-entry bank with RO and W1C entries
// and a 32-bit/latency-4 bank, checked against hand-computed values.
module tb_regs_bank;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, wen_a, ren_a;
   logic [3:0]  addr_a;
   logic [7:0]  wd_a;
   logic [0:0]  be_a;
   logic [95:0] hw_a;
   logic [7:0]  rd_a;
   logic        dr_a, wdn_a, err_a, busy_a;

   logic         rst_b, wen_b, ren_b;
   logic [3:0]   addr_b;
   logic [31:0]  wd_b;
   logic [3:0]   be_b;
   logic [511:0] hw_b;
   logic [31:0]  rd_b;
   logic         dr_b, wdn_b, err_b, busy_b;

   regs_bank #(
      .DATA_DEPTH(12), .DATA_WIDTH(8), .READ_LATENCY(1),
      .RO_MASK(12'h004), .W1C_MASK(12'h020), .RESET_VAL(8'h3C)
   ) dut_a (
      .clk(clk), .rst(rst_a), .write_en(wen_a), .read_en(ren_a), .addr(addr_a),
      .write_data(wd_a), .byte_en(be_a), .hw_in(hw_a), .read_data(rd_a),
      .data_ready(dr_a), .write_done(wdn_a), .err(err_a), .busy(busy_a)
   );

   regs_bank #(
      .DATA_DEPTH(16), .DATA_WIDTH(32), .READ_LATENCY(4), .RESET_VAL(32'hFFFF_FFFF)
   ) dut_b (
      .clk(clk), .rst(rst_b), .write_en(wen_b), .read_en(ren_b), .addr(addr_b),
      .write_data(wd_b), .byte_en(be_b), .hw_in(hw_b), .read_data(rd_b),
      .data_ready(dr_b), .write_done(wdn_b), .err(err_b), .busy(busy_b)
   );

   int          n_vec = 0;
   int          n_err = 0;
   int          n;
   logic        cap_dr, cap_wd, cap_err, cap_busy, cap_wd_after;
   logic [63:0] cap_data;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic a_wr(input logic [3:0] ad, input logic [7:0] d);
      addr_a = ad; wd_a = d; wen_a = 1'b1;
      @(negedge clk);
      cap_wd = wdn_a; cap_err = err_a; cap_busy = busy_a;
      wen_a = 1'b0;
      @(negedge clk);
      cap_wd_after = wdn_a;
   endtask

   task automatic a_rd(input logic [3:0] ad);
      addr_a = ad; ren_a = 1'b1;
      @(negedge clk);
      cap_dr = dr_a; cap_data = 64'(rd_a); cap_err = err_a;
      ren_a = 1'b0;
      @(negedge clk);
   endtask

   task automatic b_rd(input logic [3:0] ad);
      addr_b = ad; ren_b = 1'b1;
      repeat (4) @(negedge clk);
      cap_dr = dr_b; cap_data = 64'(rd_b); cap_err = err_b;
      ren_b = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst_a = 1'b1; wen_a = 1'b0; ren_a = 1'b0; addr_a = '0; wd_a = '0; be_a = 1'b1;
      hw_a = '0; hw_a[2*8 +: 8] = 8'h77;
      rst_b = 1'b1; wen_b = 1'b0; ren_b = 1'b0; addr_b = '0; wd_b = '0; be_b = 4'hF;
      hw_b = '0;
      repeat (2) @(negedge clk);
      check("a_rst_rdata", 64'(rd_a), 64'h0);
      check("a_rst_flags", {dr_a, wdn_a, err_a, busy_a}, 4'b0000);
      check("b_rst_flags", {dr_b, wdn_b, err_b, busy_b}, 4'b0000);
      rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);

      // Basic write then read-back
      a_wr(4'd3, 8'hA5);
      check("a_wr3_done", {cap_wd, cap_err, cap_busy}, 3'b101);
      check("a_wr3_pulse_end", cap_wd_after, 1'b0);
      a_rd(4'd3);
      check("a_rd3", {cap_dr, cap_err, cap_data[7:0]}, {2'b10, 8'hA5});
      a_rd(4'd4);
      check("a_rd4_resetval", cap_data, 64'h3C);

      // W1C: hardware set, then clear racing a set
      hw_a[5*8 +: 8] = 8'h0F;
      @(negedge clk);
      hw_a[5*8 +: 8] = 8'h00;
      a_rd(4'd5);
      check("a_w1c_set", cap_data, 64'h0F);
      hw_a[5*8 +: 8] = 8'h01; addr_a = 4'd5; wd_a = 8'h03; wen_a = 1'b1;
      @(negedge clk);
      hw_a[5*8 +: 8] = 8'h00; wen_a = 1'b0;
      @(negedge clk);
      a_rd(4'd5);
      check("a_w1c_set_beats_clr", cap_data, 64'h0D);
      a_wr(4'd5, 8'h0C);
      a_rd(4'd5);
      check("a_w1c_clear", cap_data, 64'h01);

      // Illegal accesses
      a_rd(4'd13);
      check("a_rd_oob", {cap_dr, cap_err, cap_data[7:0]}, {2'b11, 8'h00});
      a_wr(4'd2, 8'h11);
      check("a_wr_ro_err", {cap_wd, cap_err}, 2'b11);
      a_rd(4'd2);
      check("a_rd_ro_hw", {cap_err, cap_data[7:0]}, {1'b0, 8'h77});
      a_wr(4'd13, 8'hFF);
      check("a_wr_oob_err", {cap_wd, cap_err}, 2'b11);

      // Simultaneous rise: write wins, read dropped, held read_en never fires
      addr_a = 4'd6; wd_a = 8'h5A; wen_a = 1'b1; ren_a = 1'b1;
      @(negedge clk);
      check("a_both_wr_err", {wdn_a, err_a, dr_a}, 3'b110);
      wen_a = 1'b0; n = 0;
      repeat (10) begin @(negedge clk); if (dr_a) n++; end
      check("a_both_no_read", n, 0);
      ren_a = 1'b0;
      @(negedge clk);
      a_rd(4'd6);
      check("a_both_wrote", cap_data, 64'h5A);

      // Held read level yields one response
      addr_a = 4'd3; ren_a = 1'b1; n = 0;
      repeat (10) begin @(negedge clk); if (dr_a) n++; end
      check("a_held_read_once", n, 1);
      ren_a = 1'b0;
      @(negedge clk);

      // Level already high across reset release is not a request
      addr_a = 4'd7; wd_a = 8'h99; wen_a = 1'b1; rst_a = 1'b1;
      repeat (2) @(negedge clk);
      rst_a = 1'b0; n = 0;
      repeat (4) begin @(negedge clk); if (wdn_a) n++; end
      check("a_no_accept_after_rst", n, 0);
      wen_a = 1'b0;
      @(negedge clk);
      a_rd(4'd7);
      check("a_rd7_untouched", cap_data, 64'h3C);
      a_rd(4'd3);
      check("a_rd3_reset", cap_data, 64'h3C);
      a_rd(4'd5);
      check("a_w1c_reset", cap_data, 64'h00);

      // 32-bit byte-enable write and latency-4 read
      addr_b = 4'd1; wd_b = 32'h1122_3344; be_b = 4'b0101; wen_b = 1'b1;
      @(negedge clk);
      check("b_wr_done", {wdn_b, err_b}, 2'b10);
      wen_b = 1'b0;
      @(negedge clk);
      addr_b = 4'd1; ren_b = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("b_lat_dr", {dr_b, busy_b}, {k == 4, 1'b1});
      end
      check("b_rd_bytes", {err_b, rd_b}, {1'b0, 32'hFF22_FF44});
      ren_b = 1'b0;
      @(negedge clk);
      check("b_hold_rdata", {dr_b, busy_b, rd_b}, {2'b00, 32'hFF22_FF44});

      // Write raised while busy is ignored
      addr_b = 4'd1; ren_b = 1'b1;
      @(negedge clk);
      addr_b = 4'd2; wd_b = 32'h0; be_b = 4'hF; wen_b = 1'b1; n = 0;
      repeat (3) begin @(negedge clk); if (wdn_b) n++; end
      check("b_busy_rd_ok", {dr_b, rd_b}, {1'b1, 32'hFF22_FF44});
      wen_b = 1'b0; ren_b = 1'b0;
      @(negedge clk);
      if (wdn_b) n++;
      check("b_busy_wr_ignored", n, 0);
      b_rd(4'd2);
      check("b_rd2_unchanged", {cap_dr, cap_data[31:0]}, {1'b1, 32'hFFFF_FFFF});

      // Reset in RD_WAIT aborts the read and restores registers
      addr_b = 4'd1; ren_b = 1'b1;
      @(negedge clk);
      ren_b = 1'b0;
      @(negedge clk);
      check("b_mid_busy", {busy_b, dr_b}, 2'b10);
      rst_b = 1'b1;
      @(negedge clk);
      check("b_rst_abort", {dr_b, busy_b, err_b, rd_b}, {3'b000, 32'h0});
      rst_b = 1'b0; n = 0;
      repeat (6) begin @(negedge clk); if (dr_b) n++; end
      check("b_no_resp_after_rst", n, 0);
      b_rd(4'd1);
      check("b_rd1_reset", {cap_dr, cap_data[31:0]}, {1'b1, 32'hFFFF_FFFF});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
